// File: rtl/axil_reg_if_rd_master_if.sv
// AXI-lite read-channel bundle (AR + R) shared between a read master and a register slave.
interface axil_reg_if_rd_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output araddr, arprot, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arprot, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_reg_if_rd_master.sv
// Bridges register-style read requests onto a single-outstanding AXI-lite read master port,
// with a requester-side timeout that lets the abandoned AXI transaction drain in the background.
module axil_reg_if_rd_master #(
  parameter int         DATA_WIDTH = 32,
  parameter int         ADDR_WIDTH = 32,
  parameter int         STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [2:0] ARPROT     = 3'b000,
  parameter int         TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] reg_rd_addr,
  input  logic                  reg_rd_en,
  output logic [DATA_WIDTH-1:0] reg_rd_data,
  output logic                  reg_rd_wait,
  output logic                  reg_rd_ack,
  output logic                  reg_rd_err,
  axil_reg_if_rd_master_if.master m_axil
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_RESP,
    S_ACK,
    S_DRAIN
  } state_t;

  localparam bit                TO_EN    = (TIMEOUT > 0);
  localparam int                CNT_W    = TO_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

  if (STRB_WIDTH * 8 != DATA_WIDTH) begin : g_strb_check
    $error("STRB_WIDTH must equal DATA_WIDTH/8");
  end

  state_t                state;
  state_t                state_nxt;
  logic                  ar_pend;
  logic                  timed_out;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  err_q;

  logic accept;
  logic active;
  logic ar_hs;
  logic r_hs;
  logic expire;

  assign accept = (state == S_IDLE) && reg_rd_en;
  assign active = (state == S_ADDR) || (state == S_RESP);
  assign ar_hs  = ar_pend && m_axil.arready;
  assign r_hs   = m_axil.rvalid && m_axil.rready;
  // A response arriving in the last counted cycle wins over the timeout.
  assign expire = TO_EN && active && (cnt == '0) && !r_hs;

  // arvalid is a flag so it survives the ACK/DRAIN states after a timeout in ADDR.
  assign m_axil.araddr  = araddr_q;
  assign m_axil.arprot  = ARPROT;
  assign m_axil.arvalid = ar_pend;
  assign m_axil.rready  = (state == S_RESP) || ((state == S_DRAIN) && !ar_pend);

  assign reg_rd_data = data_q;
  assign reg_rd_err  = err_q;
  assign reg_rd_wait = active;
  assign reg_rd_ack  = (state == S_ACK);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (reg_rd_en) state_nxt = S_ADDR;
      S_ADDR: begin
        if (expire)     state_nxt = S_ACK;
        else if (ar_hs) state_nxt = S_RESP;
      end
      S_RESP:  if (expire || r_hs) state_nxt = S_ACK;
      S_ACK:   state_nxt = timed_out ? S_DRAIN : S_IDLE;
      S_DRAIN: if (!ar_pend && r_hs) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ar_pend   <= 1'b0;
      timed_out <= 1'b0;
      cnt       <= '0;
      araddr_q  <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        ar_pend   <= 1'b1;
        araddr_q  <= reg_rd_addr;
        cnt       <= CNT_LOAD;
        timed_out <= 1'b0;
      end else if (ar_hs) begin
        ar_pend <= 1'b0;
      end

      if (active && (cnt != '0)) cnt <= cnt - CNT_W'(1);

      // Drained read data never reaches the requester; only the RESP handshake is captured.
      if (expire) begin
        timed_out <= 1'b1;
        data_q    <= '0;
        err_q     <= 1'b1;
      end else if ((state == S_RESP) && r_hs) begin
        data_q <= m_axil.rdata;
        err_q  <= (m_axil.rresp != 2'b00);
      end
    end
  end

endmodule
